uart_rx_fifo: RTL and testbench

Parametrised UART receiver with a built-in receive FIFO and per-character error reporting. It converts the asynchronous `rx` line into data words with a ready/valid read handshake. It generalises the fixed 8N1 receive path of the UART top level: configurable data width, parity, stop bits, oversampling and baud divisor, plus break/glitch handling and overrun detection. It sits between the `rx` pin and the consumer, whether a command decoder or a host interface.

---
 rtl/uart_rx_fifo.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// Parametrised UART receiver: synchroniser, oversampling FSM with parity/stop checking,
// break handling, and a small receive FIFO with ready/valid read and sticky overrun.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int TICK_DIV   = 163,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clear_overrun,
  output logic                 busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [OW-1:0] HALF_LAST = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] FULL_LAST = OW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
  localparam logic          ODD       = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
  } state_t;

  state_t                 state_reg;
  logic                   rx_meta_reg, rxs_reg;
  logic [TW-1:0]          tick_cnt_reg;
  logic [OW-1:0]          os_cnt_reg;
  logic [BW-1:0]          bit_cnt_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   perr_reg, ferr_reg, commit_reg, busy_reg;
  logic [EW-1:0]          entry_reg;
  logic                   tick, start_det;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_reg <= 1'b1;
      rxs_reg     <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rxs_reg     <= rx_meta_reg;
    end
  end

  assign start_det = (state_reg == ST_IDLE) && !rxs_reg;
  assign tick      = (tick_cnt_reg == TICK_LAST);

  // Restarting on start detection phase-aligns every sample to the falling edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      tick_cnt_reg <= '0;
    else if (start_det || tick)
      tick_cnt_reg <= '0;
    else
      tick_cnt_reg <= tick_cnt_reg + TW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      os_cnt_reg  <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      commit_reg  <= 1'b0;
      entry_reg   <= '0;
      busy_reg    <= 1'b0;
    end else begin
      commit_reg <= 1'b0;
      busy_reg   <= (state_reg != ST_IDLE);
      case (state_reg)
        ST_IDLE: begin
          if (!rxs_reg) begin
            state_reg   <= ST_START;
            os_cnt_reg  <= '0;
            bit_cnt_reg <= '0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (os_cnt_reg == HALF_LAST) begin
              os_cnt_reg <= '0;
              state_reg  <= rxs_reg ? ST_IDLE : ST_DATA;
            end else begin
              os_cnt_reg <= os_cnt_reg + OW'(1);
            end
          end
        end
        ST_DATA, ST_PARITY, ST_STOP: begin
          if (tick) begin
            if (os_cnt_reg != FULL_LAST) begin
              os_cnt_reg <= os_cnt_reg + OW'(1);
            end else begin
              os_cnt_reg <= '0;
              if (state_reg == ST_DATA) begin
                shift_reg <= {rxs_reg, shift_reg[DATA_BITS-1:1]};
                if (bit_cnt_reg == DATA_LAST) begin
                  bit_cnt_reg <= '0;
                  state_reg   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                end else begin
                  bit_cnt_reg <= bit_cnt_reg + BW'(1);
                end
              end else if (state_reg == ST_PARITY) begin
                perr_reg  <= ((^shift_reg) ^ rxs_reg) != ODD;
                state_reg <= ST_STOP;
              end else begin
                ferr_reg <= ferr_reg | ~rxs_reg;
                if (bit_cnt_reg == STOP_LAST) begin
                  bit_cnt_reg <= '0;
                  entry_reg   <= {shift_reg, perr_reg, ferr_reg | ~rxs_reg};
                  commit_reg  <= 1'b1;
                  // A low final stop bit means the line may be held in break.
                  state_reg   <= rxs_reg ? ST_IDLE : ST_BREAK;
                end else begin
                  bit_cnt_reg <= bit_cnt_reg + BW'(1);
                end
              end
            end
          end
        end
        ST_BREAK: begin
          if (rxs_reg) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overrun_reg;
  logic          full, pop, push;

  assign full     = (count_reg == FULL_CNT);
  assign rd_valid = (count_reg != '0);
  assign pop      = rd_valid && rd_ready;
  // A simultaneous pop frees the slot, so a commit into a full FIFO still lands.
  assign push     = commit_reg && (!full || pop);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= entry_reg;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (commit_reg && full && !pop)
        overrun_reg <= 1'b1;
      else if (clear_overrun)
        overrun_reg <= 1'b0;
    end
  end

  assign {rd_data, parity_err, frame_err} = rd_valid ? mem[rd_ptr_reg] : '0;
  assign overrun = overrun_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx_fifo (8 data bits, even parity, 1 stop, 32 clocks per bit):
// the sender queues expected entries, a monitor pops and compares on every accepted read.
module tb_uart_rx_fifo;

  localparam int BIT_CLKS = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rd_ready = 1'b0;
  logic       clear_overrun = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, parity_err, frame_err, overrun, busy;

  int tests = 0;
  int fails = 0;
  int pops = 0;
  int valid_cycles = 0;
  int ready_mode = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  uart_rx_fifo #(
    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
    .OVERSAMPLE(16), .TICK_DIV(2), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .rx(rx),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .clear_overrun(clear_overrun), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic even_pbit(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  // Consumer readiness: 0 = stalled, 1 = always ready, otherwise ready ~75% of cycles.
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       rd_ready = 1'b0;
      1:       rd_ready = 1'b1;
      default: rd_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clock) begin
    exp_t e;
    if (rd_valid) valid_cycles++;
    if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_entry: got data %0h, required no entry", rd_data);
      end else begin
        e = exp_q.pop_front();
        check("entry_data", {24'd0, rd_data}, {24'd0, e.d});
        check("entry_parity_err", {31'd0, parity_err}, {31'd0, e.pe});
        check("entry_frame_err", {31'd0, frame_err}, {31'd0, e.fe});
        $display("[TB] pop data=%02h perr=%0b ferr=%0b", rd_data, parity_err, frame_err);
      end
      pops++;
    end
  end

  // Expected entry follows the line-level rules: even parity error when the total
  // count of ones (data + parity bit) is odd, framing error when the stop bit is low.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopv,
                            input int hold_low_bits, input bit expect_push);
    exp_t e;
    e.d  = d;
    e.pe = ((($countones(d) + int'(pbit)) % 2) != 0);
    e.fe = !stopv;
    if (expect_push) exp_q.push_back(e);
    rx = 1'b0;
    repeat (BIT_CLKS) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(posedge clock);
    end
    rx = pbit;
    repeat (BIT_CLKS) @(posedge clock);
    rx = stopv;
    repeat (BIT_CLKS) @(posedge clock);
    if (!stopv) repeat (hold_low_bits * BIT_CLKS) @(posedge clock);
    rx = 1'b1;
    if (!stopv) repeat (BIT_CLKS) @(posedge clock);
  endtask

  task automatic wait_pops(input int target, input string name);
    for (int i = 0; i < 3000 && pops < target; i++) @(posedge clock);
    check(name, pops, target);
  endtask

  initial begin
    int p, v0;
    logic [7:0] d;
    logic pb, sv;

    repeat (3) @(posedge clock);
    #1;
    check("reset_rd_valid", {31'd0, rd_valid}, 0);
    check("reset_rd_data", {24'd0, rd_data}, 0);
    check("reset_parity_err", {31'd0, parity_err}, 0);
    check("reset_frame_err", {31'd0, frame_err}, 0);
    check("reset_overrun", {31'd0, overrun}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    @(negedge clock) reset = 1'b1;
    ready_mode = 1;
    repeat (4) @(posedge clock);

    // Clean character; rd_valid must be high for a single clock.
    p = pops; v0 = valid_cycles;
    send_frame(8'hA5, even_pbit(8'hA5), 1'b1, 0, 1);
    wait_pops(p + 1, "a5_pop");
    repeat (5) @(posedge clock);
    check("a5_valid_cycles", valid_cycles - v0, 1);

    // Parity good then bad on the same data.
    p = pops;
    send_frame(8'h07, 1'b1, 1'b1, 0, 1);
    send_frame(8'h07, 1'b0, 1'b1, 0, 1);
    wait_pops(p + 2, "parity_pops");

    // Low stop bit followed by a long break: exactly one entry, then clean reception.
    p = pops;
    send_frame(8'h55, even_pbit(8'h55), 1'b0, 5, 1);
    repeat (10) @(posedge clock);
    check("break_busy_released", {31'd0, busy}, 0);
    check("break_single_entry", pops, p + 1);
    send_frame(8'h3C, even_pbit(8'h3C), 1'b1, 0, 1);
    wait_pops(p + 2, "after_break_pop");

    // Short glitch: false start, no entry.
    p = pops;
    rx = 1'b0;
    repeat (10) @(posedge clock);
    rx = 1'b1;
    repeat (40) @(posedge clock);
    check("glitch_busy", {31'd0, busy}, 0);
    check("glitch_no_entry", pops, p);
    check("glitch_overrun", {31'd0, overrun}, 0);

    // Fill the FIFO with the consumer stalled; the fifth character is dropped.
    ready_mode = 0;
    repeat (2) @(posedge clock);
    p = pops;
    for (int k = 1; k <= 5; k++) begin
      d = 8'(k);
      send_frame(d, even_pbit(d), 1'b1, 0, k <= 4);
    end
    repeat (20) @(posedge clock);
    check("overrun_set", {31'd0, overrun}, 1);
    check("overrun_head", {24'd0, rd_data}, 8'h01);
    ready_mode = 1;
    wait_pops(p + 4, "overrun_drain");
    repeat (5) @(posedge clock);
    check("overrun_empty", {31'd0, rd_valid}, 0);
    check("overrun_sticky", {31'd0, overrun}, 1);
    @(posedge clock); #1 clear_overrun = 1'b1;
    @(posedge clock); #1 clear_overrun = 1'b0;
    check("overrun_cleared", {31'd0, overrun}, 0);

    // Randomised characters, parity and stop errors, gaps and consumer stalls.
    ready_mode = 2;
    p = pops;
    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom);
      pb = even_pbit(d) ^ ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 4) != 0);
      send_frame(d, pb, sv, int'($urandom_range(0, 3)), 1);
      repeat ($urandom_range(0, 40)) @(posedge clock);
    end
    wait_pops(p + 24, "random_pops");
    check("random_overrun", {31'd0, overrun}, 0);

    // Reset mid-frame with an entry waiting: everything clears at once.
    ready_mode = 0;
    repeat (2) @(posedge clock);
    send_frame(8'h11, even_pbit(8'h11), 1'b1, 0, 1);
    d = 8'h96;
    rx = 1'b0;
    repeat (BIT_CLKS) @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(posedge clock);
    end
    rx = d[3];
    repeat (10) @(posedge clock);
    check("pre_reset_valid", {31'd0, rd_valid}, 1);
    check("pre_reset_busy", {31'd0, busy}, 1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_valid", {31'd0, rd_valid}, 0);
    check("async_reset_data", {24'd0, rd_data}, 0);
    check("async_reset_busy", {31'd0, busy}, 0);
    check("async_reset_overrun", {31'd0, overrun}, 0);
    exp_q.delete();
    rx = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    ready_mode = 1;
    repeat (4) @(posedge clock);
    p = pops;
    send_frame(8'hC3, even_pbit(8'hC3), 1'b1, 0, 1);
    wait_pops(p + 1, "post_reset_pop");
    repeat (400) @(posedge clock);
    check("post_reset_no_spurious", pops, p + 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
